// File: rtl/systolic_scheduler_pkg.sv
// rtl/systolic_scheduler_pkg.sv - shared state encoding and width helper for the systolic scheduler
// Purpose: FSM state type and the step-counter width function used by the top and the bench.
// Ports: none (package).
package systolic_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter must reach T_END+1 = 2N-1+K_MAX without wrapping.
    function automatic int cnt_width(input int n, input int k_max);
        return $clog2(k_max + 2 * n);
    endfunction

endpackage

// File: rtl/systolic_scheduler_if.sv
// rtl/systolic_scheduler_if.sv - job request and PE-array control bundle for the systolic scheduler
// Purpose: groups the job request, stall and all schedule outputs.
// Ports: master drives start/k_len/stall and observes the schedule; slave is the scheduler.
interface systolic_scheduler_if #(
    parameter int N  = 4,
    parameter int KW = 9
);
    logic            start;
    logic [KW-1:0]   k_len;
    logic            stall;
    logic [N-1:0]    row_en;
    logic [N-1:0]    col_en;
    logic            acc_clr;
    logic [N*N-1:0]  pe_finish;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, k_len, stall,
        input  row_en, col_en, acc_clr, pe_finish, busy, done, err
    );

    modport slave (
        input  start, k_len, stall,
        output row_en, col_en, acc_clr, pe_finish, busy, done, err
    );
endinterface

// File: rtl/sa_skew_gen.sv
// rtl/sa_skew_gen.sv - skew-window compare logic for row/column feeds and PE finish pulses
// Purpose: decodes step t and inner dimension K into the skewed feed enables and finish pulses.
// Ports: i_t step count, i_k latched K, i_active (RUN and not stalled);
//        o_row_en / o_col_en per-row/col feed enables, o_pe_finish per-PE finish (index i*N+j).
module sa_skew_gen #(
    parameter int N  = 4,
    parameter int CW = 9
) (
    input  logic [CW-1:0]   i_t,
    input  logic [CW-1:0]   i_k,
    input  logic            i_active,
    output logic [N-1:0]    o_row_en,
    output logic [N-1:0]    o_col_en,
    output logic [N*N-1:0]  o_pe_finish
);

    logic [N-1:0] w_win;

    // Row i and column i share the same skew (i cycles late, K cycles wide).
    always_comb begin
        w_win       = '0;
        o_pe_finish = '0;
        for (int i = 0; i < N; i++) begin
            w_win[i] = i_active && (i_t >= CW'(i)) && (i_t < CW'(i) + i_k);
            for (int j = 0; j < N; j++) begin
                // Last operand pair reaches PE(i,j) at step i+j+K-1.
                o_pe_finish[i*N+j] = i_active && (i_t == CW'(i + j) + i_k);
            end
        end
    end

    assign o_row_en = w_win;
    assign o_col_en = w_win;

endmodule

// File: rtl/systolic_scheduler.sv
// rtl/systolic_scheduler.sv - sequences one output-stationary NxN matrix multiply on the PE array
// Purpose: FSM, latched K, step counter and done/err; the skew windows live in sa_skew_gen.
// Ports: i_clk, i_rst (async, active-high); bus (slave) carries start/k_len/stall in and
//        row_en/col_en/acc_clr/pe_finish/busy/done/err out.
module systolic_scheduler
    import systolic_scheduler_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int K_MAX      = 256,
    parameter int KW         = $clog2(K_MAX + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    systolic_scheduler_if.slave bus
);

    localparam int CW = cnt_width(ARRAY_SIZE, K_MAX);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_t;
    logic [KW-1:0]   r_k;
    logic            r_err;

    logic            w_k_bad;
    logic            w_active;
    logic            w_last;
    logic [CW-1:0]   w_k_ext;
    logic [CW-1:0]   w_t_end;

    assign w_k_bad  = (bus.k_len == '0) || (bus.k_len > KW'(K_MAX));
    assign w_k_ext  = CW'(r_k);
    assign w_t_end  = CW'(2 * ARRAY_SIZE - 2) + w_k_ext;
    assign w_active = (r_state == ST_RUN) && !bus.stall;
    // A stall on the final step holds everything, including the exit to DONE.
    assign w_last   = w_active && (r_t == w_t_end);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = w_k_bad ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:                w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_k     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && bus.start) begin
                r_t   <= '0;
                r_err <= w_k_bad;
                if (!w_k_bad) r_k <= bus.k_len;
            end else if (w_active) begin
                r_t <= r_t + CW'(1);
            end
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.err     = (r_state == ST_DONE) && r_err;
    assign bus.acc_clr = w_active && (r_t == '0);

    sa_skew_gen #(
        .N  (ARRAY_SIZE),
        .CW (CW)
    ) u_skew (
        .i_t         (r_t),
        .i_k         (w_k_ext),
        .i_active    (w_active),
        .o_row_en    (bus.row_en),
        .o_col_en    (bus.col_en),
        .o_pe_finish (bus.pe_finish)
    );

endmodule
